// File: rtl/fir_engine.sv
// fir_engine: time-multiplexed single-MAC FIR filter.
// One sample is accepted per strobe into a circular delay line, then one tap
// is accumulated per clock. The scaled, saturated result is presented with a
// one-cycle valid pulse. Coefficients are writable only while the engine is idle.
module fir_engine #(
  parameter int DataWidth  = 12,
  parameter int CoeffWidth = 12,
  parameter int NumTaps    = 16
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic signed [DataWidth-1:0]    sampleIn,
  input  logic                           sampleInValid,
  output logic signed [DataWidth-1:0]    sampleOut,
  output logic                           sampleOutValid,
  output logic                           busy,
  output logic                           sampleDropped,
  input  logic                           coeffWrEn,
  input  logic [$clog2(NumTaps)-1:0]     coeffAddr,
  input  logic signed [CoeffWidth-1:0]   coeffData,
  output logic                           coeffWrReady
);

  localparam int AddrWidth = $clog2(NumTaps);
  localparam int ProdWidth = DataWidth + CoeffWidth;
  localparam int AccWidth  = DataWidth + CoeffWidth + $clog2(NumTaps);

  typedef enum logic [1:0] {IDLE, MAC, OUTPUT} state_t;

  state_t                       state;
  logic signed [DataWidth-1:0]  delay [NumTaps];
  logic signed [CoeffWidth-1:0] coeff [NumTaps];
  logic [AddrWidth-1:0]         write_ptr;
  logic [AddrWidth-1:0]         tap_idx;
  logic signed [AccWidth-1:0]   acc;

  logic                         accept;
  logic [AddrWidth-1:0]         next_ptr;
  logic [AddrWidth-1:0]         read_idx;
  logic signed [ProdWidth-1:0]  product;
  logic signed [AccWidth-1:0]   product_ext;
  logic signed [AccWidth-1:0]   shifted;
  logic signed [DataWidth-1:0]  sat_value;
  logic                         fits;

  assign busy         = (state != IDLE);
  assign coeffWrReady = !busy;
  assign accept       = (state == IDLE) && sampleInValid;
  assign next_ptr     = write_ptr + 1'b1;

  // Tap k pairs coeff[k] with the sample k steps older than the newest one;
  // index arithmetic wraps naturally because NumTaps is a power of two.
  assign read_idx    = write_ptr - tap_idx;
  assign product     = coeff[tap_idx] * delay[read_idx];
  assign product_ext = {{(AccWidth-ProdWidth){product[ProdWidth-1]}}, product};

  // Drop the Q1 fractional bits with floor rounding, then clamp: the result
  // fits only when every bit above the output sign bit matches the sign.
  assign shifted   = acc >>> (CoeffWidth - 1);
  assign fits      = (&shifted[AccWidth-1:DataWidth-1]) || !(|shifted[AccWidth-1:DataWidth-1]);
  assign sat_value = fits ? shifted[DataWidth-1:0]
                   : (shifted[AccWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}}
                                          : {1'b0, {(DataWidth-1){1'b1}}});

  // Delay line: the accepted sample lands one slot ahead of the current write pointer.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NumTaps; i++) delay[i] <= '0;
    end else if (accept) begin
      delay[next_ptr] <= sampleIn;
    end
  end

  // Coefficient bank: writes land only while idle, so a running MAC never sees a change.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NumTaps; i++) coeff[i] <= '0;
    end else if (coeffWrEn && !busy) begin
      coeff[coeffAddr] <= coeffData;
    end
  end

  // Control FSM with accumulator, result register and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      write_ptr      <= '0;
      tap_idx        <= '0;
      acc            <= '0;
      sampleOut      <= '0;
      sampleOutValid <= 1'b0;
      sampleDropped  <= 1'b0;
    end else begin
      sampleOutValid <= 1'b0;
      case (state)
        IDLE: begin
          if (sampleInValid) begin
            write_ptr <= next_ptr;
            acc       <= '0;
            tap_idx   <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          acc     <= acc + product_ext;
          tap_idx <= tap_idx + 1'b1;
          if (tap_idx == AddrWidth'(NumTaps - 1)) state <= OUTPUT;
        end
        OUTPUT: begin
          sampleOut      <= sat_value;
          sampleOutValid <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (busy && sampleInValid) sampleDropped <= 1'b1;
    end
  end

endmodule
